// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stage_sequencer
// Description : Frame-level controller for the scrolling stage renderer:
//               game FSM, per-frame map scroll, BCD score, renderer start/reset.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_sequencer #(
    parameter int               MAP_W        = 16,
    parameter logic [MAP_W-1:0] MAP_END      = 16'd4000,
    parameter int               SPEED_W      = 4,
    parameter int               SCORE_PERIOD = 30,
    parameter int               LOAD_TIMEOUT = 8
) (
    input  logic               i_clk_pix,
    input  logic               i_rst,
    input  logic               i_frame_start,
    input  logic               i_play,
    input  logic               i_pause,
    input  logic               i_collide,
    input  logic [SPEED_W-1:0] i_speed,
    input  logic               i_stage_ready,
    output logic               o_stage_start,
    output logic               o_stage_rst_n,
    output logic [MAP_W-1:0]   o_map_x,
    output logic [2:0]         o_state,
    output logic               o_win,
    output logic               o_load_err,
    output logic [15:0]        o_score
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int FC_W = (SCORE_PERIOD > 1) ? $clog2(SCORE_PERIOD) : 1;
    localparam int LC_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [FC_W-1:0] c_FC_LAST = FC_W'(SCORE_PERIOD - 1);
    localparam logic [LC_W-1:0] c_LC_LAST = LC_W'(LOAD_TIMEOUT - 1);

    state_t            r_state;
    logic [MAP_W-1:0]  r_map_x;
    logic [15:0]       r_score;
    logic [FC_W-1:0]   r_frame_cnt;
    logic [LC_W-1:0]   r_load_cnt;
    logic              r_win;
    logic              r_load_err;
    logic              r_stage_start;
    logic              r_stage_rst_n;

    logic [MAP_W:0]    w_next_x;
    logic              w_reach_end;
    logic [15:0]       w_score_inc;

    // Per-digit BCD increment; holds at the 4-digit maximum.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (v[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // One extra bit so a step past the end of the map cannot wrap.
    assign w_next_x    = {1'b0, r_map_x} + {{(MAP_W + 1 - SPEED_W){1'b0}}, i_speed};
    assign w_reach_end = (w_next_x >= {1'b0, MAP_END});
    assign w_score_inc = bcd_inc(r_score);

    always_ff @(posedge i_clk_pix) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_map_x       <= '0;
            r_score       <= '0;
            r_frame_cnt   <= '0;
            r_load_cnt    <= '0;
            r_win         <= 1'b0;
            r_load_err    <= 1'b0;
            r_stage_start <= 1'b0;
            r_stage_rst_n <= 1'b0;
        end else begin
            r_stage_start <= 1'b0;
            r_stage_rst_n <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (i_play) begin
                        r_state       <= ST_LOAD;
                        r_stage_start <= 1'b1;
                        r_load_err    <= 1'b0;
                        r_load_cnt    <= '0;
                    end
                end
                ST_LOAD: begin
                    // Ready is checked first so it wins over a coincident timeout.
                    if (i_stage_ready) begin
                        r_state <= ST_RUN;
                    end else if (i_frame_start) begin
                        if (r_load_cnt == c_LC_LAST) begin
                            r_state       <= ST_IDLE;
                            r_load_err    <= 1'b1;
                            r_stage_rst_n <= 1'b0;
                        end else begin
                            r_load_cnt <= r_load_cnt + LC_W'(1);
                        end
                    end
                end
                ST_RUN: begin
                    if (i_collide) begin
                        r_state <= ST_OVER;
                        r_win   <= 1'b0;
                    end else if (i_frame_start && w_reach_end) begin
                        r_state <= ST_OVER;
                        r_map_x <= MAP_END;
                        r_win   <= 1'b1;
                    end else if (i_pause) begin
                        r_state <= ST_PAUSE;
                    end else if (i_frame_start) begin
                        r_map_x <= w_next_x[MAP_W-1:0];
                    end

                    // Score cadence follows every frame that actually advanced the map.
                    if (!i_collide && i_frame_start && (w_reach_end || !i_pause)) begin
                        if (r_frame_cnt == c_FC_LAST) begin
                            r_frame_cnt <= '0;
                            r_score     <= w_score_inc;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + FC_W'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (i_pause) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_OVER: begin
                    if (i_play) begin
                        r_state       <= ST_IDLE;
                        r_map_x       <= '0;
                        r_score       <= '0;
                        r_frame_cnt   <= '0;
                        r_win         <= 1'b0;
                        r_stage_rst_n <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_stage_start = r_stage_start;
    assign o_stage_rst_n = r_stage_rst_n;
    assign o_map_x       = r_map_x;
    assign o_state       = r_state;
    assign o_win         = r_win;
    assign o_load_err    = r_load_err;
    assign o_score       = r_score;

endmodule
`default_nettype wire
